// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bundle: predictor, execute redirect, hazard controls and IF/ID outputs
// IF_PERF_EN adds the FetchCountO/RedirectCountO counter outputs.
interface if_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] InstrF;
  logic [DATA_WIDTH-1:0] PCF;
  logic [DATA_WIDTH-1:0] PCBPU;
  logic                  PCBPUSrc;
  logic                  flushBranch;
  logic                  JumpE;
  logic [DATA_WIDTH-1:0] PCTargetE;
  logic                  StallF;
  logic                  StallD;
  logic                  FlushD;
  logic [DATA_WIDTH-1:0] InstrD;
  logic [DATA_WIDTH-1:0] PCD;
  logic [DATA_WIDTH-1:0] PCPlus4D;
  logic                  ValidD;
  logic                  PredTakenD;
`ifdef IF_PERF_EN
  logic [31:0]           FetchCountO;
  logic [31:0]           RedirectCountO;
`endif

  modport master (
`ifdef IF_PERF_EN
    input  FetchCountO, RedirectCountO,
`endif
    output InstrF, PCBPU, PCBPUSrc, flushBranch, JumpE, PCTargetE,
    output StallF, StallD, FlushD,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD, PredTakenD
  );

  modport slave (
`ifdef IF_PERF_EN
    output FetchCountO, RedirectCountO,
`endif
    input  InstrF, PCBPU, PCBPUSrc, flushBranch, JumpE, PCTargetE,
    input  StallF, StallD, FlushD,
    output PCF, InstrD, PCD, PCPlus4D, ValidD, PredTakenD
  );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I fetch stage: fetch PC, next-PC select and IF/ID register
// Optional IF_PERF_EN: saturating fetch and redirect counters.
module if_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input logic       clk,
  input logic       rst,
  if_stage_if.slave fetch
);

  logic [DATA_WIDTH-1:0] r_pcf;
  logic [DATA_WIDTH-1:0] r_instr_d;
  logic [DATA_WIDTH-1:0] r_pc_d;
  logic [DATA_WIDTH-1:0] r_pc_plus4_d;
  logic                  r_valid_d;
  logic                  r_pred_taken_d;

  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_pc_sel;
  logic [DATA_WIDTH-1:0] w_pc_next;
  logic                  w_redirect;
  logic                  w_kill;
  logic                  w_capture;

  assign w_pc_plus4 = r_pcf + DATA_WIDTH'(4);
  assign w_redirect = fetch.flushBranch | fetch.JumpE;
  assign w_kill     = w_redirect | fetch.FlushD;
  assign w_capture  = !w_kill && !fetch.StallD && !fetch.StallF;

  // Redirects beat StallF; a prediction under StallF is dropped and re-made on refetch.
  always_comb begin
    w_pc_sel = w_pc_plus4;
    if (fetch.flushBranch)   w_pc_sel = fetch.PCBPU;
    else if (fetch.JumpE)    w_pc_sel = fetch.PCTargetE;
    else if (fetch.StallF)   w_pc_sel = r_pcf;
    else if (fetch.PCBPUSrc) w_pc_sel = fetch.PCBPU;
  end

  assign w_pc_next = {w_pc_sel[DATA_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcf <= RESET_PC;
    end else begin
      r_pcf <= w_pc_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_d      <= NOP_INSTR;
      r_pc_d         <= '0;
      r_pc_plus4_d   <= '0;
      r_valid_d      <= 1'b0;
      r_pred_taken_d <= 1'b0;
    end else if (w_kill || (fetch.StallF && !fetch.StallD)) begin
      // Kill and fetch-stall bubble both present a cleared NOP to decode.
      r_instr_d      <= NOP_INSTR;
      r_pc_d         <= '0;
      r_pc_plus4_d   <= '0;
      r_valid_d      <= 1'b0;
      r_pred_taken_d <= 1'b0;
    end else if (w_capture) begin
      r_instr_d      <= fetch.InstrF;
      r_pc_d         <= r_pcf;
      r_pc_plus4_d   <= w_pc_plus4;
      r_valid_d      <= 1'b1;
      r_pred_taken_d <= fetch.PCBPUSrc;
    end
  end

  assign fetch.PCF        = r_pcf;
  assign fetch.InstrD     = r_instr_d;
  assign fetch.PCD        = r_pc_d;
  assign fetch.PCPlus4D   = r_pc_plus4_d;
  assign fetch.ValidD     = r_valid_d;
  assign fetch.PredTakenD = r_pred_taken_d;

`ifdef IF_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_redirect_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt    <= '0;
      r_redirect_cnt <= '0;
    end else begin
      if (w_capture && (r_fetch_cnt != 32'hFFFF_FFFF))
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_redirect && (r_redirect_cnt != 32'hFFFF_FFFF))
        r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

  assign fetch.FetchCountO    = r_fetch_cnt;
  assign fetch.RedirectCountO = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed-vector bench for if_stage
// Builds with or without IF_PERF_EN; counter checks run only when it is defined.
module tb_if_stage;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  if_stage_if #(.DATA_WIDTH(32)) bus ();

  if_stage dut (
    .clk   (clk),
    .rst   (rst),
    .fetch (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: a fixed, PC-dependent word so captures can be told apart.
  assign bus.InstrF = bus.PCF ^ 32'hCAFE_0000;

  task automatic clear_inputs();
    bus.PCBPU       = '0;
    bus.PCBPUSrc    = 1'b0;
    bus.flushBranch = 1'b0;
    bus.JumpE       = 1'b0;
    bus.PCTargetE   = '0;
    bus.StallF      = 1'b0;
    bus.StallD      = 1'b0;
    bus.FlushD      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #12;
    n_vec++; if (bus.PCF !== 32'h0) begin n_err++; $display("FAIL rst_pcf: got %h want %h", bus.PCF, 32'h0); end
    n_vec++; if (bus.InstrD !== 32'h13) begin n_err++; $display("FAIL rst_instrd: got %h want %h", bus.InstrD, 32'h13); end
    n_vec++; if (bus.PCD !== 32'h0) begin n_err++; $display("FAIL rst_pcd: got %h want %h", bus.PCD, 32'h0); end
    n_vec++; if (bus.PCPlus4D !== 32'h0) begin n_err++; $display("FAIL rst_pcplus4d: got %h want %h", bus.PCPlus4D, 32'h0); end
    n_vec++; if (bus.ValidD !== 1'b0) begin n_err++; $display("FAIL rst_validd: got %b want 0", bus.ValidD); end
    n_vec++; if (bus.PredTakenD !== 1'b0) begin n_err++; $display("FAIL rst_predtaken: got %b want 0", bus.PredTakenD); end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++; if (bus.PCD !== 32'(4 * i)) begin n_err++; $display("FAIL seq_pcd[%0d]: got %h want %h", i, bus.PCD, 32'(4 * i)); end
      n_vec++; if (bus.PCPlus4D !== 32'(4 * i + 4)) begin n_err++; $display("FAIL seq_pcplus4d[%0d]: got %h want %h", i, bus.PCPlus4D, 32'(4 * i + 4)); end
      n_vec++; if (bus.ValidD !== 1'b1) begin n_err++; $display("FAIL seq_validd[%0d]: got %b want 1", i, bus.ValidD); end
      n_vec++; if (bus.InstrD !== (32'(4 * i) ^ 32'hCAFE_0000)) begin n_err++; $display("FAIL seq_instrd[%0d]: got %h want %h", i, bus.InstrD, 32'(4 * i) ^ 32'hCAFE_0000); end
      n_vec++; if (bus.PCF !== 32'(4 * i + 4)) begin n_err++; $display("FAIL seq_pcf[%0d]: got %h want %h", i, bus.PCF, 32'(4 * i + 4)); end
    end
  endtask

  task automatic test_predict();
    bus.PCBPUSrc = 1'b1;
    bus.PCBPU    = 32'h40;
    step();
    clear_inputs();
    n_vec++; if (bus.PCF !== 32'h40) begin n_err++; $display("FAIL pred_pcf: got %h want %h", bus.PCF, 32'h40); end
    n_vec++; if (bus.PCD !== 32'h10) begin n_err++; $display("FAIL pred_pcd: got %h want %h", bus.PCD, 32'h10); end
    n_vec++; if (bus.PredTakenD !== 1'b1) begin n_err++; $display("FAIL pred_taken: got %b want 1", bus.PredTakenD); end
    step();
    n_vec++; if (bus.PCF !== 32'h44) begin n_err++; $display("FAIL pred_pcf2: got %h want %h", bus.PCF, 32'h44); end
    n_vec++; if (bus.PredTakenD !== 1'b0) begin n_err++; $display("FAIL pred_taken2: got %b want 0", bus.PredTakenD); end
  endtask

  task automatic test_mispredict();
    bus.flushBranch = 1'b1;
    bus.PCBPU       = 32'h14;
    bus.JumpE       = 1'b1;
    bus.PCTargetE   = 32'h80;
    step();
    clear_inputs();
    n_vec++; if (bus.PCF !== 32'h14) begin n_err++; $display("FAIL misp_pcf: got %h want %h", bus.PCF, 32'h14); end
    n_vec++; if (bus.ValidD !== 1'b0) begin n_err++; $display("FAIL misp_validd: got %b want 0", bus.ValidD); end
    n_vec++; if (bus.InstrD !== 32'h13) begin n_err++; $display("FAIL misp_instrd: got %h want %h", bus.InstrD, 32'h13); end
    step();
    n_vec++; if (bus.PCD !== 32'h14) begin n_err++; $display("FAIL misp_pcd: got %h want %h", bus.PCD, 32'h14); end
    n_vec++; if (bus.ValidD !== 1'b1) begin n_err++; $display("FAIL misp_validd2: got %b want 1", bus.ValidD); end
    // FlushD alone squashes decode but lets fetch advance.
    bus.FlushD = 1'b1;
    step();
    clear_inputs();
    n_vec++; if (bus.PCF !== 32'h1C) begin n_err++; $display("FAIL flushd_pcf: got %h want %h", bus.PCF, 32'h1C); end
    n_vec++; if (bus.ValidD !== 1'b0) begin n_err++; $display("FAIL flushd_validd: got %b want 0", bus.ValidD); end
    step();
  endtask

  task automatic test_stall();
    bus.StallF = 1'b1;
    bus.StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.PCBPUSrc = (i == 1);
      bus.PCBPU    = 32'h300;
      step();
      n_vec++; if (bus.PCF !== 32'h20) begin n_err++; $display("FAIL stall_pcf[%0d]: got %h want %h", i, bus.PCF, 32'h20); end
      n_vec++; if (bus.PCD !== 32'h1C) begin n_err++; $display("FAIL stall_pcd[%0d]: got %h want %h", i, bus.PCD, 32'h1C); end
      n_vec++; if (bus.InstrD !== (32'h1C ^ 32'hCAFE_0000)) begin n_err++; $display("FAIL stall_instrd[%0d]: got %h want %h", i, bus.InstrD, 32'h1C ^ 32'hCAFE_0000); end
    end
    clear_inputs();
    bus.StallF = 1'b1;
    step();
    n_vec++; if (bus.PCF !== 32'h20) begin n_err++; $display("FAIL bubble_pcf: got %h want %h", bus.PCF, 32'h20); end
    n_vec++; if (bus.ValidD !== 1'b0) begin n_err++; $display("FAIL bubble_validd: got %b want 0", bus.ValidD); end
    n_vec++; if (bus.InstrD !== 32'h13) begin n_err++; $display("FAIL bubble_instrd: got %h want %h", bus.InstrD, 32'h13); end
    bus.JumpE     = 1'b1;
    bus.PCTargetE = 32'h100;
    step();
    clear_inputs();
    n_vec++; if (bus.PCF !== 32'h100) begin n_err++; $display("FAIL stalljmp_pcf: got %h want %h", bus.PCF, 32'h100); end
    n_vec++; if (bus.ValidD !== 1'b0) begin n_err++; $display("FAIL stalljmp_validd: got %b want 0", bus.ValidD); end
    step();
    n_vec++; if (bus.PCD !== 32'h100) begin n_err++; $display("FAIL stalljmp_pcd: got %h want %h", bus.PCD, 32'h100); end
  endtask

  task automatic test_boundary();
    bus.JumpE     = 1'b1;
    bus.PCTargetE = 32'h203;
    step();
    n_vec++; if (bus.PCF !== 32'h200) begin n_err++; $display("FAIL align_pcf: got %h want %h", bus.PCF, 32'h200); end
    bus.PCTargetE = 32'hFFFF_FFFE;
    step();
    clear_inputs();
    n_vec++; if (bus.PCF !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pcf0: got %h want %h", bus.PCF, 32'hFFFF_FFFC); end
    step();
    n_vec++; if (bus.PCF !== 32'h0) begin n_err++; $display("FAIL wrap_pcf: got %h want %h", bus.PCF, 32'h0); end
    n_vec++; if (bus.PCD !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pcd: got %h want %h", bus.PCD, 32'hFFFF_FFFC); end
    n_vec++; if (bus.PCPlus4D !== 32'h0) begin n_err++; $display("FAIL wrap_pcplus4d: got %h want %h", bus.PCPlus4D, 32'h0); end
    step();
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_vec++; if (bus.PCF !== 32'h0) begin n_err++; $display("FAIL midrst_pcf: got %h want %h", bus.PCF, 32'h0); end
    n_vec++; if (bus.ValidD !== 1'b0) begin n_err++; $display("FAIL midrst_validd: got %b want 0", bus.ValidD); end
    n_vec++; if (bus.PCD !== 32'h0) begin n_err++; $display("FAIL midrst_pcd: got %h want %h", bus.PCD, 32'h0); end
    rst = 1'b0;
    step();
    n_vec++; if (bus.PCF !== 32'h4) begin n_err++; $display("FAIL midrst_pcf2: got %h want %h", bus.PCF, 32'h4); end
    n_vec++; if (bus.ValidD !== 1'b1) begin n_err++; $display("FAIL midrst_validd2: got %b want 1", bus.ValidD); end
  endtask

`ifdef IF_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    #2;
    n_vec++; if (bus.FetchCountO !== 32'd0) begin n_err++; $display("FAIL perf_fetch_rst: got %0d want 0", bus.FetchCountO); end
    n_vec++; if (bus.RedirectCountO !== 32'd0) begin n_err++; $display("FAIL perf_redir_rst: got %0d want 0", bus.RedirectCountO); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin bus.JumpE = 1'b1; bus.PCTargetE = 32'h400; end
      else begin bus.flushBranch = 1'b1; bus.PCBPU = 32'h500; end
      step();
      clear_inputs();
      step();
    end
    n_vec++; if (bus.FetchCountO !== 32'd13) begin n_err++; $display("FAIL perf_fetch: got %0d want 13", bus.FetchCountO); end
    n_vec++; if (bus.RedirectCountO !== 32'd3) begin n_err++; $display("FAIL perf_redir: got %0d want 3", bus.RedirectCountO); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_predict();
    test_mispredict();
    test_stall();
    test_boundary();
    test_reset_mid();
`ifdef IF_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined RV32I core: holds the fetch PC, selects the next PC and registers the IF/ID pipeline boundary. It drives `PCF` to instruction memory and to the branch predictor. It consumes the predictor's `PCBPU`/`PCBPUSrc`/`flushBranch` outputs and the Execute-stage jump redirect, and squashes wrong-path instructions already fetched.

## Interface
- `DATA_WIDTH`, 32, datapath and PC width.
- `RESET_PC`, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- `NOP_INSTR`, 32'h0000_0013, instruction word loaded into `InstrD` on flush/reset (`addi x0,x0,0`).
- Reset and clock (decided): reset `rst`, asynchronous, active-high; clock `clk`.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `InstrF`  in  DATA_WIDTH  instruction word read combinationally from instruction memory at `PCF`.
- `PCF`  out  DATA_WIDTH  current fetch PC (registered).
- `PCBPU`  in  DATA_WIDTH  predictor target address or correction address.
- `PCBPUSrc`  in  1  predictor requests redirect to `PCBPU`.
- `flushBranch`  in  1  predictor reports a mispredict; `PCBPU` holds the correct PC.
- `JumpE`  in  1  jal/jalr resolved in Execute.
- `PCTargetE`  in  DATA_WIDTH  jump target from Execute.
- `StallF`  in  1  hazard unit: hold `PCF`.
- `StallD`  in  1  hazard unit: hold IF/ID.
- `FlushD`  in  1  hazard unit: squash IF/ID.
- `InstrD`  out  DATA_WIDTH  decode instruction.
- `PCD`  out  DATA_WIDTH  PC of `InstrD`.
- `PCPlus4D`  out  DATA_WIDTH  `PCD`+4.
- `ValidD`  out  1  `InstrD` is a real, non-squashed instruction.
- `PredTakenD`  out  1  predictor predicted taken for `InstrD`.

## Operation
- Next-PC priority, highest first:
  1. `flushBranch` → `PCBPU`
  2. `JumpE` → `PCTargetE`
  3. `StallF` → hold `PCF`
  4. `PCBPUSrc` → `PCBPU`
  5. otherwise → `PCF`+4
- Redirects (priorities 1 and 2) override `StallF`.
- A prediction while `StallF` is asserted is ignored. The instruction is refetched and predicted again.
- Next-PC bits [1:0] are forced to 0.
- All PC arithmetic is modulo 2^DATA_WIDTH: `PCF`=32'hFFFF_FFFC advances to 32'h0.
- IF/ID update, highest priority first:
  1. Kill (`flushBranch` | `JumpE` | `FlushD`): `InstrD`=NOP_INSTR, `ValidD`=0, `PredTakenD`=0; `PCD`/`PCPlus4D` are don't-care but are cleared to 0.
  2. `StallD`: all IF/ID outputs hold.
  3. Otherwise capture: `InstrD`=`InstrF`, `PCD`=`PCF`, `PCPlus4D`=`PCF`+4, `ValidD`=1, `PredTakenD`=`PCBPUSrc`.
- A kill overrides `StallD`.
- `StallF`=1 with `StallD`=0 and no kill inserts a bubble: `ValidD`=0, `InstrD`=NOP_INSTR.

## Timing
- Reset values (asynchronous, immediate on `rst` assert): `PCF`=RESET_PC, `InstrD`=NOP_INSTR, `PCD`=0, `PCPlus4D`=0, `ValidD`=0, `PredTakenD`=0, perf counters 0.
- First rising edge after `rst` deasserts: `PCD`=RESET_PC, `ValidD`=1, `PCF`=RESET_PC+4.
- Redirect latency: 1 cycle. Any redirect sampled at edge N appears on `PCF` after edge N.
- Mispredict penalty: the instruction in F at the redirect edge is never captured, and the instruction in D is killed.
- `rst` asserted mid-operation discards all in-flight state in the same cycle.

## Configuration
- `IF_PERF_EN` defined: adds two outputs.
  - `FetchCountO` (32): increments on every edge where IF/ID captures with `ValidD`←1.
  - `RedirectCountO` (32): increments on every edge with `flushBranch`|`JumpE`.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- `IF_PERF_EN` undefined: both ports and both counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then 4 free-running cycles → `PCD` = 0x0, 0x4, 0x8, 0xC; `ValidD`=1; `PCPlus4D`=`PCD`+4.
- `PCF`=0x10, `PCBPUSrc`=1, `PCBPU`=0x40 → next `PCF`=0x40; `PCD`=0x10; `PredTakenD`=1.
- `PCF`=0x44, `flushBranch`=1, `PCBPU`=0x14, with `JumpE`=1 and `PCTargetE`=0x80 in the same cycle → `PCF`=0x14; `ValidD`=0; `InstrD`=0x13.
- `StallF`=`StallD`=1 for 3 cycles at `PCF`=0x20 → `PCF`, `InstrD` and `PCD` hold. `StallF`=1 plus `JumpE`=1, `PCTargetE`=0x100 → `PCF`=0x100 and `ValidD`=0.
- `PCF` forced to 0xFFFF_FFFC → next `PCF`=0x0. `rst` pulsed mid-run → `PCF`=RESET_PC and `ValidD`=0 immediately.
- With `IF_PERF_EN`: 10 fetches, 2 jumps, 1 mispredict → `FetchCountO` equals the number of captured valid instructions; `RedirectCountO`=3.
